// File: rtl/rv_pkg.sv
// Shared constants for the core's register-file write path: data/address
// widths, register count and the arbiter's grant encodings.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int AREG_W = 5;
  localparam int NREG   = 32;

  // Grant encodings; last_grant holds one of these.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  // The requester that should win a tie given who won last.
  function automatic logic rr_tie_winner(input logic last_grant);
    return (last_grant == REQ_ALU) ? REQ_LD : REQ_ALU;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Per-register busy scoreboard. A bit is set when decode issues a writer to
// that register and cleared on the cycle the write is presented to reg_file.
// A newer issue beats a same-cycle clear; flush beats everything.
// x0 never reads busy.
module rf_scoreboard
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AREG_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [AREG_W-1:0] clr_rd,
  input  logic              flush,
  input  logic [AREG_W-1:0] rs1,
  input  logic [AREG_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // x0 is hardwired zero, so it can never have an outstanding write.
  assign busy_d[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit    = set_en && (set_rd == AREG_W'(gi));
      assign clr_hit    = clr_en && (clr_rd == AREG_W'(gi));
      assign busy_d[gi] = flush   ? 1'b0 :
                          set_hit ? 1'b1 :
                          clr_hit ? 1'b0 : busy_q[gi];
    end
  endgenerate

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read ports see only registered state: no bypass of a same-cycle commit.
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the reg_file write port. Round-robin arbitrates ALU and load
// writebacks, registers the winner onto rf_we/rf_rd/rf_wdata one cycle after
// the handshake, and maintains the RAW busy scoreboard for decode.
module rf_write_arbiter
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AREG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AREG_W-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              issue_valid,
  input  logic [AREG_W-1:0] issue_rd,
  input  logic              flush,
  input  logic [AREG_W-1:0] rs1,
  input  logic [AREG_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [AREG_W-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);

  logic              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [AREG_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic              grant_alu, grant_ld;
  logic              hs_any;
  logic [AREG_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

  // Round-robin grant: a lone requester always wins; on a tie the side that
  // did not win last time is granted. Ready is never raised without valid.
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (alu_valid && ld_valid) begin
      grant_alu = (rr_tie_winner(last_grant_q) == REQ_ALU);
      grant_ld  = (rr_tie_winner(last_grant_q) == REQ_LD);
    end else begin
      grant_alu = alu_valid;
      grant_ld  = ld_valid;
    end
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;
  assign hs_any    = grant_alu || grant_ld;
  assign win_rd    = grant_ld ? ld_rd   : alu_rd;
  assign win_data  = grant_ld ? ld_data : alu_data;

  // Next-state for the grant history and the commit register. A write to x0
  // is consumed but never reaches the port; address/data then hold.
  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (hs_any) begin
      last_grant_d = grant_ld ? REQ_LD : REQ_ALU;
      if (win_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = win_rd;
        rf_wdata_d = win_data;
      end
    end
  end

  // Grant history and registered write port; reset drops any pending commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_LD;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  // The scoreboard clears on the presented write, so busy drops at the same
  // edge that reg_file captures the data.
  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_valid),
    .set_rd   (issue_rd),
    .clr_en   (rf_we_q),
    .clr_rd   (rf_rd_q),
    .flush    (flush),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  // Requesters must hold a pending request unchanged until it is accepted.
  a_alu_hold: assert property (@(posedge clk) disable iff (rst)
    (alu_valid && !alu_ready) |=> (alu_valid && $stable(alu_rd) && $stable(alu_data)));
  a_ld_hold: assert property (@(posedge clk) disable iff (rst)
    (ld_valid && !ld_ready) |=> (ld_valid && $stable(ld_rd) && $stable(ld_data)));
  a_one_grant: assert property (@(posedge clk) disable iff (rst)
    !(alu_ready && ld_ready));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a cycle-level reference model checked
// on every falling edge, plus hand-computed expectations per scenario.
module tb_rf_write_arbiter;
  import rv_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_ready, ld_valid, ld_ready;
  logic [AREG_W-1:0] alu_rd, ld_rd, issue_rd, rs1, rs2, rf_rd;
  logic [XLEN-1:0]   alu_data, ld_data, rf_wdata;
  logic              issue_valid, flush, rs1_busy, rs2_busy, rf_we;

  int n_cmp = 0;
  int n_bad = 0;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the port and scoreboard must show this cycle.
  bit              m_last_ld;   // 1 when the load unit won the last handshake
  bit              m_we;
  logic [4:0]      m_rd;
  logic [31:0]     m_wdata;
  bit [31:0]       m_busy;

  initial begin
    bit e_alu, e_ld;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_last_ld = 1'b1;
        m_we      = 1'b0;
        m_rd      = '0;
        m_wdata   = '0;
        m_busy    = '0;
      end
      e_alu = alu_valid && (!ld_valid || m_last_ld);
      e_ld  = ld_valid && (!alu_valid || !m_last_ld);
      chk("model.alu_ready", alu_ready, e_alu);
      chk("model.ld_ready",  ld_ready,  e_ld);
      chk("model.rf_we",     rf_we,     m_we);
      chk("model.rf_rd",     rf_rd,     m_rd);
      chk("model.rf_wdata",  rf_wdata,  m_wdata);
      chk("model.rs1_busy",  rs1_busy,  m_busy[rs1]);
      chk("model.rs2_busy",  rs2_busy,  m_busy[rs2]);
      if (!rst) begin
        // Scoreboard for the next cycle, using the write presented now.
        if (flush) begin
          m_busy = '0;
        end else begin
          if (m_we) m_busy[m_rd] = 1'b0;
          if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        // Commit for the next cycle.
        m_we = 1'b0;
        if (e_alu || e_ld) begin
          m_last_ld = e_ld;
          if ((e_ld ? ld_rd : alu_rd) != 0) begin
            m_we    = 1'b1;
            m_rd    = e_ld ? ld_rd : alu_rd;
            m_wdata = e_ld ? ld_data : alu_data;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_rd[5] = '{3, 4, 3, 4, 3};
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_valid = 0; issue_rd = 0; flush = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mid();
    chk("reset.rf_we", rf_we, 1'b0);
    chk("reset.rf_wdata", rf_wdata, 32'h0);

    // Both requesters every cycle: ALU, LD, ALU, LD, then ALU alone.
    for (int k = 0; k < 5; k++) begin
      cyc();
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
      ld_valid = (k < 4); ld_rd = 5'd4; ld_data = 32'h44;
      mid();
      chk("rr.alu_ready", alu_ready, (k % 2 == 0));
      chk("rr.both_ready", alu_ready & ld_ready, 1'b0);
      if (k > 0) chk("rr.rf_rd", rf_rd, exp_rd[k-1]);
    end
    cyc();
    alu_valid = 0; ld_valid = 0;
    mid();
    chk("rr.last_rd", rf_rd, exp_rd[4]);
    chk("rr.last_data", rf_wdata, 32'h33);

    // Single ALU write with one-cycle commit latency.
    cyc();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    mid();
    chk("alu.ready", alu_ready, 1'b1);
    cyc();
    alu_valid = 0;
    mid();
    chk("alu.rf_we", rf_we, 1'b1);
    chk("alu.rf_rd", rf_rd, 5'd5);
    chk("alu.rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    cyc();
    mid();
    chk("alu.rf_we_drop", rf_we, 1'b0);

    // Issue rd=7, load writes it back three cycles later.
    cyc();
    issue_valid = 1; issue_rd = 5'd7; rs1 = 5'd7;
    mid();
    chk("raw.busy_issue_cycle", rs1_busy, 1'b0);
    cyc();
    issue_valid = 0;
    mid();
    chk("raw.busy_c1", rs1_busy, 1'b1);
    cyc();
    mid();
    chk("raw.busy_c2", rs1_busy, 1'b1);
    cyc();
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77;
    mid();
    chk("raw.ld_ready", ld_ready, 1'b1);
    chk("raw.busy_c3", rs1_busy, 1'b1);
    cyc();
    ld_valid = 0;
    mid();
    chk("raw.rf_we", rf_we, 1'b1);
    chk("raw.busy_c4", rs1_busy, 1'b1);
    cyc();
    mid();
    chk("raw.busy_cleared", rs1_busy, 1'b0);

    // Same-cycle reissue while the write lands keeps rd=7 busy.
    cyc();
    issue_valid = 1; issue_rd = 5'd7;
    cyc();
    issue_valid = 0;
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h707;
    cyc();
    ld_valid = 0;
    issue_valid = 1; issue_rd = 5'd7;
    mid();
    chk("reissue.rf_we", rf_we, 1'b1);
    cyc();
    issue_valid = 0;
    mid();
    chk("reissue.busy", rs1_busy, 1'b1);

    // Write to x0 is consumed but never presented.
    cyc();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
    issue_valid = 1; issue_rd = 5'd0; rs2 = 5'd0;
    mid();
    chk("x0.ready", alu_ready, 1'b1);
    cyc();
    alu_valid = 0; issue_valid = 0;
    mid();
    chk("x0.rf_we", rf_we, 1'b0);
    chk("x0.busy", rs2_busy, 1'b0);

    // Flush with a pending commit and a concurrent issue and handshake.
    cyc();
    issue_valid = 1; issue_rd = 5'd9;
    cyc();
    issue_rd = 5'd10; rs1 = 5'd9; rs2 = 5'd10;
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2222;
    cyc();
    alu_valid = 0;
    issue_rd = 5'd11; flush = 1;
    ld_valid = 1; ld_rd = 5'd12; ld_data = 32'hC;
    mid();
    chk("flush.rf_we", rf_we, 1'b1);
    chk("flush.rf_rd", rf_rd, 5'd2);
    chk("flush.busy9_pre", rs1_busy, 1'b1);
    chk("flush.busy10_pre", rs2_busy, 1'b1);
    cyc();
    issue_valid = 0; flush = 0; ld_valid = 0;
    mid();
    chk("flush.busy9", rs1_busy, 1'b0);
    chk("flush.busy10", rs2_busy, 1'b0);
    chk("flush.hs_commit", rf_rd, 5'd12);
    cyc();
    rs1 = 5'd11; rs2 = 5'd7;
    mid();
    chk("flush.busy11", rs1_busy, 1'b0);
    chk("flush.busy7", rs2_busy, 1'b0);

    // Asynchronous reset mid-cycle with a commit and busy bit outstanding.
    cyc();
    issue_valid = 1; issue_rd = 5'd6; rs1 = 5'd6;
    alu_valid = 1; alu_rd = 5'd8; alu_data = 32'h88;
    cyc();
    issue_valid = 0; alu_valid = 0;
    #1;
    chk("arst.pre_we", rf_we, 1'b1);
    chk("arst.pre_busy", rs1_busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst.rf_we", rf_we, 1'b0);
    chk("arst.rs1_busy", rs1_busy, 1'b0);
    chk("arst.rs2_busy", rs2_busy, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    mid();
    chk("arst.after_we", rf_we, 1'b0);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
